// File: rtl/hazard_ctrl_mdu.sv
// Hazard unit for the 5-stage MIPS core: Tnew/Tuse stalls, D/E/M forward selects,
// the internal multiply/divide busy counter, the EPC-before-eret stall and a stall counter.
module hazard_ctrl_mdu #(
    parameter int RA_W     = 5,
    parameter int T_W      = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   rs_d,
    input  logic [RA_W-1:0]   rt_d,
    input  logic [RA_W-1:0]   rs_e,
    input  logic [RA_W-1:0]   rt_e,
    input  logic [RA_W-1:0]   rt_m,
    input  logic [RA_W-1:0]   dst_e,
    input  logic [RA_W-1:0]   dst_m,
    input  logic [RA_W-1:0]   dst_w,
    input  logic [T_W-1:0]    tuse_rs_d,
    input  logic [T_W-1:0]    tuse_rt_d,
    input  logic [T_W-1:0]    tnew_e,
    input  logic [T_W-1:0]    tnew_m,
    input  logic              link_e,
    input  logic              link_m,
    input  logic              mdu_start_e,
    input  logic              mdu_div_e,
    input  logic              mdu_use_d,
    input  logic              eret_d,
    input  logic              mtc0_epc_e,
    input  logic              mtc0_epc_m,
    input  logic              flush,
    output logic              en_pc,
    output logic              en_d,
    output logic              bubble_e,
    output logic [2:0]        fwd_rs_d,
    output logic [2:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0]  r_mdu_cnt;
    logic [PERF_W-1:0] r_stall_cnt;
    logic w_rs_d_e, w_rt_d_e, w_rs_d_m, w_rt_d_m, w_rs_d_w, w_rt_d_w;
    logic w_rs_e_m, w_rt_e_m, w_rs_e_w, w_rt_e_w;
    logic w_stall_dat, w_stall_mdu, w_stall_epc, w_stall;

    // Register 0 is hardwired, so a zero destination never produces a dependency.
    function automatic logic match(input logic [RA_W-1:0] src, input logic [RA_W-1:0] dst);
        return (src == dst) && (src != '0);
    endfunction

    function automatic logic [2:0] sel_d(input logic me, input logic mm, input logic mw);
        if (me && link_e)      return 3'd4;
        else if (mm && link_m) return 3'd3;
        else if (mm)           return 3'd2;
        else if (mw)           return 3'd1;
        else                   return 3'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic mm, input logic mw);
        if (mm && link_m) return 2'd3;
        else if (mm)      return 2'd2;
        else if (mw)      return 2'd1;
        else              return 2'd0;
    endfunction

    assign w_rs_d_e = match(rs_d, dst_e);
    assign w_rt_d_e = match(rt_d, dst_e);
    assign w_rs_d_m = match(rs_d, dst_m);
    assign w_rt_d_m = match(rt_d, dst_m);
    assign w_rs_d_w = match(rs_d, dst_w);
    assign w_rt_d_w = match(rt_d, dst_w);
    assign w_rs_e_m = match(rs_e, dst_m);
    assign w_rt_e_m = match(rt_e, dst_m);
    assign w_rs_e_w = match(rs_e, dst_w);
    assign w_rt_e_w = match(rt_e, dst_w);

    assign fwd_rs_d = sel_d(w_rs_d_e, w_rs_d_m, w_rs_d_w);
    assign fwd_rt_d = sel_d(w_rt_d_e, w_rt_d_m, w_rt_d_w);
    assign fwd_rs_e = sel_e(w_rs_e_m, w_rs_e_w);
    assign fwd_rt_e = sel_e(w_rt_e_m, w_rt_e_w);
    assign fwd_rt_m = match(rt_m, dst_w);

    // Link results carry tnew=0, so they fall out of the comparison without special casing.
    assign w_stall_dat = ((tuse_rs_d < tnew_e) && w_rs_d_e) || ((tuse_rt_d < tnew_e) && w_rt_d_e) ||
                         ((tuse_rs_d < tnew_m) && w_rs_d_m) || ((tuse_rt_d < tnew_m) && w_rt_d_m);
    assign w_stall_mdu = mdu_use_d && (mdu_busy || mdu_start_e);
    assign w_stall_epc = eret_d && (mtc0_epc_e || mtc0_epc_m);
    assign w_stall     = w_stall_dat || w_stall_mdu || w_stall_epc;

    assign en_pc     = !w_stall || flush;
    assign en_d      = !w_stall || flush;
    assign bubble_e  = w_stall && !flush;
    assign mdu_busy  = (r_mdu_cnt != '0);
    assign stall_cnt = r_stall_cnt;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdu_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            // A running count survives flush; only a new, unflushed issue reloads it.
            if (mdu_start_e && !flush)
                r_mdu_cnt <= mdu_div_e ? L_DIV : L_MULT;
            else if (r_mdu_cnt != '0)
                r_mdu_cnt <= r_mdu_cnt - 1'b1;
            if (bubble_e && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Self-checking bench for hazard_ctrl_mdu: vector table for the combinational selects,
// hand sequences for MDU timing, flush interaction and stall-counter saturation.
module tb_hazard_ctrl_mdu;

    localparam int PERF_W = 4;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, rt_m, dst_e, dst_m, dst_w;
        logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
        logic       link_e, link_m, mdu_start_e, mdu_div_e, mdu_use_d;
        logic       eret_d, mtc0_epc_e, mtc0_epc_m, flush;
    } vec_t;

    typedef struct packed {
        logic       en;
        logic       bubble;
        logic [2:0] frs_d, frt_d;
        logic [1:0] frs_e, frt_e;
        logic       frt_m;
    } comb_t;

    typedef struct packed {
        vec_t  v;
        comb_t c;
    } rec_t;

    typedef struct packed {
        comb_t             c;
        logic              busy;
        logic [PERF_W-1:0] sc;
    } exp_t;

    logic clk = 1'b0;
    vec_t cur;
    logic en_pc, en_d, bubble_e, fwd_rt_m, mdu_busy;
    logic [2:0] fwd_rs_d, fwd_rt_d;
    logic [1:0] fwd_rs_e, fwd_rt_e;
    logic [PERF_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt = 0;
    int m_stall = 0;
    exp_t sb[$];
    rec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl_mdu #(.PERF_W(PERF_W)) dut (
        .clk(clk), .reset(cur.reset),
        .rs_d(cur.rs_d), .rt_d(cur.rt_d), .rs_e(cur.rs_e), .rt_e(cur.rt_e), .rt_m(cur.rt_m),
        .dst_e(cur.dst_e), .dst_m(cur.dst_m), .dst_w(cur.dst_w),
        .tuse_rs_d(cur.tuse_rs_d), .tuse_rt_d(cur.tuse_rt_d),
        .tnew_e(cur.tnew_e), .tnew_m(cur.tnew_m),
        .link_e(cur.link_e), .link_m(cur.link_m),
        .mdu_start_e(cur.mdu_start_e), .mdu_div_e(cur.mdu_div_e), .mdu_use_d(cur.mdu_use_d),
        .eret_d(cur.eret_d), .mtc0_epc_e(cur.mtc0_epc_e), .mtc0_epc_m(cur.mtc0_epc_m),
        .flush(cur.flush),
        .en_pc(en_pc), .en_d(en_d), .bubble_e(bubble_e),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .fwd_rt_m(fwd_rt_m), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    function automatic comb_t mc(input int en, input int bub, input int a, input int b,
                                 input int c, input int d, input int m);
        comb_t r;
        r.en = en[0]; r.bubble = bub[0];
        r.frs_d = 3'(a); r.frt_d = 3'(b);
        r.frs_e = 2'(c); r.frt_e = 2'(d);
        r.frt_m = m[0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: push the expectation, compare on the falling edge, advance the model.
    task automatic step(input string tag, input vec_t v, input comb_t c);
        exp_t e;
        cur = v;
        e.c = c;
        e.busy = (m_cnt != 0);
        e.sc = PERF_W'(m_stall);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".en_pc"},    32'(en_pc),     32'(e.c.en));
        check({tag, ".en_d"},     32'(en_d),      32'(e.c.en));
        check({tag, ".bubble_e"}, 32'(bubble_e),  32'(e.c.bubble));
        check({tag, ".fwd_rs_d"}, 32'(fwd_rs_d),  32'(e.c.frs_d));
        check({tag, ".fwd_rt_d"}, 32'(fwd_rt_d),  32'(e.c.frt_d));
        check({tag, ".fwd_rs_e"}, 32'(fwd_rs_e),  32'(e.c.frs_e));
        check({tag, ".fwd_rt_e"}, 32'(fwd_rt_e),  32'(e.c.frt_e));
        check({tag, ".fwd_rt_m"}, 32'(fwd_rt_m),  32'(e.c.frt_m));
        check({tag, ".mdu_busy"}, 32'(mdu_busy),  32'(e.busy));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
        if (v.reset) begin
            m_cnt = 0;
            m_stall = 0;
        end else begin
            if (c.bubble && m_stall != (1 << PERF_W) - 1) m_stall++;
            if (v.mdu_start_e && !v.flush) m_cnt = v.mdu_div_e ? 10 : 5;
            else if (m_cnt != 0) m_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        comb_t idle_c;
        idle_c = mc(1, 0, 0, 0, 0, 0, 0);

        v = '0; tbl.push_back('{v, idle_c});
        v = '0; v.rs_d = 1; v.dst_e = 1; v.tnew_e = 2;                tbl.push_back('{v, mc(0, 1, 0, 0, 0, 0, 0)});
        v = '0; v.rs_d = 1; v.dst_m = 1; v.tnew_m = 1;                tbl.push_back('{v, mc(0, 1, 2, 0, 0, 0, 0)});
        v = '0; v.rs_d = 1; v.dst_w = 1;                              tbl.push_back('{v, mc(1, 0, 1, 0, 0, 0, 0)});
        v = '0; v.rs_d = 31; v.dst_e = 31; v.link_e = 1;              tbl.push_back('{v, mc(1, 0, 4, 0, 0, 0, 0)});
        v = '0; v.rs_d = 31; v.dst_m = 31; v.link_m = 1;              tbl.push_back('{v, mc(1, 0, 3, 0, 0, 0, 0)});
        v = '0; v.rt_d = 3; v.dst_e = 3; v.link_e = 1; v.dst_m = 3; v.link_m = 1; v.dst_w = 3;
                                                                      tbl.push_back('{v, mc(1, 0, 0, 4, 0, 0, 0)});
        v = '0; v.rt_d = 4; v.dst_m = 4; v.dst_w = 4;                 tbl.push_back('{v, mc(1, 0, 0, 2, 0, 0, 0)});
        v = '0; v.tnew_e = 2; v.tnew_m = 2;                           tbl.push_back('{v, idle_c});
        v = '0; v.rs_d = 5; v.dst_e = 5; v.tnew_e = 1; v.tuse_rs_d = 1; tbl.push_back('{v, idle_c});
        v = '0; v.rt_d = 6; v.dst_e = 6; v.tnew_e = 2; v.tuse_rt_d = 1; tbl.push_back('{v, mc(0, 1, 0, 0, 0, 0, 0)});
        v = '0; v.rt_d = 6; v.dst_m = 6; v.tnew_m = 2; v.tuse_rt_d = 1; tbl.push_back('{v, mc(0, 1, 0, 2, 0, 0, 0)});
        v = '0; v.rs_e = 7; v.rt_e = 8; v.dst_m = 7; v.dst_w = 8;     tbl.push_back('{v, mc(1, 0, 0, 0, 2, 1, 0)});
        v = '0; v.rs_e = 9; v.rt_e = 9; v.dst_m = 9; v.link_m = 1; v.dst_w = 9;
                                                                      tbl.push_back('{v, mc(1, 0, 0, 0, 3, 3, 0)});
        v = '0; v.rt_m = 10; v.dst_w = 10;                            tbl.push_back('{v, mc(1, 0, 0, 0, 0, 0, 1)});
        v = '0; v.rt_m = 10; v.dst_m = 10;                            tbl.push_back('{v, idle_c});
        v = '0; v.rs_d = 1; v.dst_e = 1; v.tnew_e = 2; v.flush = 1;   tbl.push_back('{v, idle_c});
        v = '0; v.eret_d = 1; v.mtc0_epc_m = 1;                       tbl.push_back('{v, mc(0, 1, 0, 0, 0, 0, 0)});
        v = '0; v.eret_d = 1; v.mtc0_epc_e = 1;                       tbl.push_back('{v, mc(0, 1, 0, 0, 0, 0, 0)});
        v = '0; v.eret_d = 1; v.mtc0_epc_m = 1; v.flush = 1;          tbl.push_back('{v, idle_c});
        v = '0; v.mtc0_epc_m = 1;                                     tbl.push_back('{v, idle_c});

        // Unchecked first edge so registers leave X before the reset-state comparison.
        cur = '0; cur.reset = 1'b1;
        @(posedge clk);
        #1;
        v = '0; v.reset = 1; step("reset", v, idle_c);

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].v, tbl[i].c);

        // div then mflo: stalled for the issue cycle plus 10 busy cycles; counter saturates.
        v = '0; v.mdu_start_e = 1; v.mdu_div_e = 1; v.mdu_use_d = 1;
        step("div_issue", v, mc(0, 1, 0, 0, 0, 0, 0));
        v = '0; v.mdu_use_d = 1;
        for (int i = 1; i <= 10; i++) step($sformatf("div_busy%0d", i), v, mc(0, 1, 0, 0, 0, 0, 0));
        step("div_release", v, idle_c);
        v = '0; v.reset = 1; step("sat_reset", v, idle_c);
        v = '0; step("after_reset", v, idle_c);

        // Flushed mult start is ignored.
        v = '0; v.mdu_start_e = 1; v.mdu_use_d = 1; v.flush = 1;
        step("mult_flush", v, idle_c);
        v = '0; v.mdu_use_d = 1; step("mfhi_after_flush", v, idle_c);

        // mult busy for 5 cycles; a flush mid-count does not clear it.
        v = '0; v.mdu_start_e = 1; step("mult_issue", v, idle_c);
        for (int i = 1; i <= 5; i++) begin
            v = '0; v.flush = (i == 2);
            step($sformatf("mult_busy%0d", i), v, idle_c);
        end
        v = '0; step("mult_done", v, idle_c);

        // Reset mid-divide clears the count at once.
        v = '0; v.mdu_start_e = 1; v.mdu_div_e = 1; step("div2_issue", v, idle_c);
        v = '0; step("div2_run1", v, idle_c);
        step("div2_run2", v, idle_c);
        v = '0; v.reset = 1; step("div2_reset", v, idle_c);
        v = '0; step("div2_after", v, idle_c);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
